// File: rtl/dbi_pkg.sv
// dbi_pkg: definitions shared by the DBI Type-B PHYs.
//   - default data bus width
//   - DCX level meanings
//   - Type-B write strobe and hardware-reset timing, in seconds
//   - RX FSM state encoding
package dbi_pkg;

  localparam int DBI_IF_D_W = 8;

  localparam logic DCX_CMD = 1'b0;
  localparam logic DCX_PAR = 1'b1;

  localparam real T_WRL_SEC  = 15e-9;
  localparam real T_WRH_SEC  = 15e-9;
  localparam real T_HRST_SEC = 10e-6;

  typedef enum logic [1:0] {
    IDLE_ST      = 2'd0,
    SEL_ST       = 2'd1,
    HRST_ST      = 2'd2,
    HRST_HOLD_ST = 2'd3
  } dbi_rx_state_e;

endpackage

// File: rtl/dbi_rx_fifo.sv
// dbi_rx_fifo: small synchronous FIFO for received DBI bytes.
//   clk, rst : clock, async active-high reset
//   flush_i  : empties the FIFO (wins over push/pop in the same cycle)
//   push_i   : write wdat_i; accepted when not full, or when full with a pop
//   full_o   : FIFO holds DEPTH entries
//   pop_i    : consume the head entry (ignored when empty)
//   rdat_o   : head entry, read straight from the storage flops
//   empty_o  : FIFO holds no entries
module dbi_rx_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] wdat_i,
  output logic         full_o,
  input  logic         pop_i,
  output logic [W-1:0] rdat_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         wr_en, rd_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rd_en    = pop_i & ~empty_o;
    // When full, the slot being written is the head being popped this cycle.
    wr_en    = push_i & (~full_o | rd_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  assign rdat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (wr_en && !flush_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdat_i;
    end
  end

endmodule

// File: rtl/dbi_rx_phy.sv
// dbi_rx_phy: MIPI DBI Type-B (8080) write receiver.
//   clk, rst        : system clock, async active-high reset
//   dbi_*_i         : asynchronous DBI pins (CSX/WRX/RESX active low); RDX unused
//   drf_rx_dat_o    : head byte of the receive FIFO
//   drf_rx_dcx_o    : DCX level captured with the head byte
//   drf_rx_first_o  : head byte is the first one after CSX fell
//   drf_rx_vld_o    : FIFO non-empty
//   drf_rx_rdy_i    : consumer takes the head on vld & rdy
//   drf_rx_end_o    : one-cycle pulse when CSX rises
//   drf_hrst_o      : one-cycle pulse on a qualified RESX low period
//   drf_ovf_o       : sticky, a byte was dropped on a full FIFO
module dbi_rx_phy #(
  parameter int  INTERNAL_CLK   = 125000000,
  parameter int  DBI_IF_D_W     = dbi_pkg::DBI_IF_D_W,
  parameter int  FIFO_DEPTH     = 4,
  parameter real T_HRST_MIN_SEC = dbi_pkg::T_HRST_SEC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DBI_IF_D_W-1:0] dbi_d_i,
  input  logic                  dbi_csx_i,
  input  logic                  dbi_dcx_i,
  input  logic                  dbi_resx_i,
  input  logic                  dbi_rdx_i,
  input  logic                  dbi_wrx_i,
  output logic [DBI_IF_D_W-1:0] drf_rx_dat_o,
  output logic                  drf_rx_dcx_o,
  output logic                  drf_rx_first_o,
  output logic                  drf_rx_vld_o,
  input  logic                  drf_rx_rdy_i,
  output logic                  drf_rx_end_o,
  output logic                  drf_hrst_o,
  output logic                  drf_ovf_o
);

  import dbi_pkg::*;

  localparam int HRST_MIN_CYC = $rtoi(T_HRST_MIN_SEC * INTERNAL_CLK);
  localparam int CNT_W        = $clog2(HRST_MIN_CYC + 1);
  localparam logic [CNT_W-1:0] HRST_CNT = CNT_W'(HRST_MIN_CYC);
  localparam int ENT_W        = DBI_IF_D_W + 2;

  // Reads are not supported; the strobe is deliberately left unconnected.
  logic rdx_unused;
  assign rdx_unused = dbi_rdx_i;

  logic                  csx_s1_q, csx_s2_q, csx_s3_q;
  logic                  wrx_s1_q, wrx_s2_q, wrx_s3_q;
  logic                  resx_s1_q, resx_s2_q, resx_s3_q;
  logic                  dcx_s1_q, dcx_s2_q;
  logic [DBI_IF_D_W-1:0] d_s1_q, d_s2_q;
  logic [2:0]            warm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csx_s1_q  <= 1'b1;
      csx_s2_q  <= 1'b1;
      csx_s3_q  <= 1'b1;
      wrx_s1_q  <= 1'b1;
      wrx_s2_q  <= 1'b1;
      wrx_s3_q  <= 1'b1;
      resx_s1_q <= 1'b1;
      resx_s2_q <= 1'b1;
      resx_s3_q <= 1'b1;
      dcx_s1_q  <= 1'b0;
      dcx_s2_q  <= 1'b0;
      d_s1_q    <= '0;
      d_s2_q    <= '0;
      warm_q    <= '0;
    end else begin
      csx_s1_q  <= dbi_csx_i;
      csx_s2_q  <= csx_s1_q;
      csx_s3_q  <= csx_s2_q;
      wrx_s1_q  <= dbi_wrx_i;
      wrx_s2_q  <= wrx_s1_q;
      wrx_s3_q  <= wrx_s2_q;
      resx_s1_q <= dbi_resx_i;
      resx_s2_q <= resx_s1_q;
      resx_s3_q <= resx_s2_q;
      dcx_s1_q  <= dbi_dcx_i;
      dcx_s2_q  <= dcx_s1_q;
      d_s1_q    <= dbi_d_i;
      d_s2_q    <= d_s1_q;
      warm_q    <= {warm_q[1:0], 1'b1};
    end
  end

  dbi_rx_state_e    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             first_q, end_q, hrst_q, ovf_q;

  logic             wr_rise, csx_fall, csx_rise, capture, pop, hrst_qual;
  logic             fifo_full, fifo_empty;
  logic [ENT_W-1:0] fifo_wdat, fifo_rdat;

  always_comb begin
    wr_rise   = wrx_s2_q & ~wrx_s3_q;
    // Until three edges have passed since rst, csx_s3 still holds its reset
    // level, so a pin already low would look like a fresh fall.
    csx_fall  = warm_q[2] & ~csx_s2_q & csx_s3_q;
    csx_rise  = csx_s2_q & ~csx_s3_q;
    capture   = wr_rise & ~csx_s2_q & (state_q == SEL_ST);
    pop       = ~fifo_empty & drf_rx_rdy_i;
    hrst_qual = (state_q == HRST_ST) & ~resx_s2_q & (cnt_q == HRST_CNT);
    fifo_wdat = {dcx_s2_q, first_q, d_s2_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE_ST;
      cnt_q   <= '0;
      first_q <= 1'b0;
      end_q   <= 1'b0;
      hrst_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      end_q  <= 1'b0;
      hrst_q <= 1'b0;
      if (capture) first_q <= 1'b0;
      if (capture && fifo_full && !pop) ovf_q <= 1'b1;
      case (state_q)
        IDLE_ST: begin
          if (!resx_s2_q) begin
            state_q <= HRST_ST;
            cnt_q   <= CNT_W'(1);
          end else if (csx_fall) begin
            state_q <= SEL_ST;
            first_q <= 1'b1;
          end
        end
        SEL_ST: begin
          if (!resx_s2_q) begin
            state_q <= HRST_ST;
            cnt_q   <= CNT_W'(1);
          end else if (csx_rise) begin
            state_q <= IDLE_ST;
            end_q   <= 1'b1;
          end
        end
        HRST_ST: begin
          if (resx_s2_q) begin
            state_q <= IDLE_ST;
            cnt_q   <= '0;
          end else if (hrst_qual) begin
            state_q <= HRST_HOLD_ST;
            hrst_q  <= 1'b1;
            ovf_q   <= 1'b0;
            first_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HRST_HOLD_ST: begin
          if (resx_s2_q) begin
            state_q <= IDLE_ST;
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE_ST;
      endcase
    end
  end

  dbi_rx_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (hrst_qual),
    .push_i  (capture),
    .wdat_i  (fifo_wdat),
    .full_o  (fifo_full),
    .pop_i   (pop),
    .rdat_o  (fifo_rdat),
    .empty_o (fifo_empty)
  );

  assign drf_rx_dat_o   = fifo_rdat[DBI_IF_D_W-1:0];
  assign drf_rx_first_o = fifo_rdat[DBI_IF_D_W];
  assign drf_rx_dcx_o   = fifo_rdat[DBI_IF_D_W+1];
  assign drf_rx_vld_o   = ~fifo_empty;
  assign drf_rx_end_o   = end_q;
  assign drf_hrst_o     = hrst_q;
  assign drf_ovf_o      = ovf_q;

endmodule

// File: tb/tb_dbi_rx_phy.sv
module tb_dbi_rx_phy;
  import dbi_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dbi_d = '0;
  logic       dbi_csx = 1'b1, dbi_dcx = 1'b0, dbi_resx = 1'b1;
  logic       dbi_rdx = 1'b1, dbi_wrx = 1'b1;
  logic [7:0] rx_dat;
  logic       rx_dcx, rx_first, rx_vld, rx_end, hrst, ovf;
  logic       rx_rdy = 1'b0;

  always #5 clk = ~clk;

  dbi_rx_phy dut (
    .clk            (clk),
    .rst            (rst),
    .dbi_d_i        (dbi_d),
    .dbi_csx_i      (dbi_csx),
    .dbi_dcx_i      (dbi_dcx),
    .dbi_resx_i     (dbi_resx),
    .dbi_rdx_i      (dbi_rdx),
    .dbi_wrx_i      (dbi_wrx),
    .drf_rx_dat_o   (rx_dat),
    .drf_rx_dcx_o   (rx_dcx),
    .drf_rx_first_o (rx_first),
    .drf_rx_vld_o   (rx_vld),
    .drf_rx_rdy_i   (rx_rdy),
    .drf_rx_end_o   (rx_end),
    .drf_hrst_o     (hrst),
    .drf_ovf_o      (ovf)
  );

  typedef struct {
    logic [7:0] dat;
    logic       dcx;
    logic       first;
  } obs_t;

  typedef struct {
    logic       dcx;
    logic [7:0] d;
    logic [7:0] exp_dat;
    logic       exp_dcx;
    logic       exp_first;
  } vec_t;

  obs_t obs_q[$];
  int   end_cnt  = 0;
  int   hrst_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Sampled mid-cycle: vld & rdy here is the pop that happens at the next edge.
  always @(negedge clk) begin
    if (rx_vld && rx_rdy) obs_q.push_back('{dat: rx_dat, dcx: rx_dcx, first: rx_first});
    if (rx_end) end_cnt++;
    if (hrst) hrst_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic dcx, input logic [7:0] d);
    dbi_dcx = dcx;
    dbi_d   = d;
    dbi_wrx = 1'b0;
    tick(4);
    dbi_wrx = 1'b1;
    tick(4);
  endtask

  vec_t vecs[4];
  obs_t exp_ovf[4];
  int   e0, h0;

  initial begin
    vecs[0] = '{DCX_CMD, 8'h3A, 8'h3A, 1'b0, 1'b1};
    vecs[1] = '{DCX_PAR, 8'h55, 8'h55, 1'b1, 1'b0};
    vecs[2] = '{DCX_PAR, 8'hAA, 8'hAA, 1'b1, 1'b0};
    vecs[3] = '{DCX_PAR, 8'h01, 8'h01, 1'b1, 1'b0};
    exp_ovf[0] = '{8'h10, 1'b1, 1'b1};
    exp_ovf[1] = '{8'h11, 1'b1, 1'b0};
    exp_ovf[2] = '{8'h12, 1'b1, 1'b0};
    exp_ovf[3] = '{8'h13, 1'b1, 1'b0};

    // Reset state
    tick(3);
    chk("rst_vld", rx_vld, 0);
    chk("rst_end", rx_end, 0);
    chk("rst_hrst", hrst, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dat", rx_dat, 0);
    chk("rst_first", rx_first, 0);
    rst = 1'b0;
    tick(4);

    // Single command with exact capture and end-pulse latency
    dbi_csx = 1'b0;
    tick(4);
    dbi_dcx = DCX_CMD; dbi_d = 8'h2C; dbi_wrx = 1'b0;
    tick(4);
    dbi_wrx = 1'b1;
    tick(1); chk("cmd_vld_n", rx_vld, 0);
    tick(1); chk("cmd_vld_n1", rx_vld, 0);
    tick(1); chk("cmd_vld_n2", rx_vld, 1);
    chk("cmd_dat", rx_dat, 8'h2C);
    chk("cmd_dcx", rx_dcx, 0);
    chk("cmd_first", rx_first, 1);
    rx_rdy = 1'b1;
    tick(1);
    rx_rdy = 1'b0;
    chk("cmd_popped", rx_vld, 0);
    tick(2);
    e0 = end_cnt;
    dbi_csx = 1'b1;
    tick(1); chk("end_n", rx_end, 0);
    tick(1); chk("end_n1", rx_end, 0);
    tick(1); chk("end_n2", rx_end, 1);
    tick(1); chk("end_n3", rx_end, 0);
    tick(3);
    chk("end_once", end_cnt - e0, 1);

    // Command plus parameters, consumer always ready
    obs_q.delete();
    rx_rdy = 1'b1;
    dbi_csx = 1'b0;
    tick(4);
    for (int i = 0; i < 4; i++) wr_byte(vecs[i].dcx, vecs[i].d);
    dbi_csx = 1'b1;
    tick(6);
    chk("seq_count", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      chk($sformatf("seq_dat%0d", i), obs_q[i].dat, vecs[i].exp_dat);
      chk($sformatf("seq_dcx%0d", i), obs_q[i].dcx, vecs[i].exp_dcx);
      chk($sformatf("seq_first%0d", i), obs_q[i].first, vecs[i].exp_first);
    end

    // WRX with CSX high must not push
    rx_rdy = 1'b0;
    wr_byte(DCX_PAR, 8'hEE);
    tick(2);
    chk("csx_high_nopush", rx_vld, 0);

    // Overflow: 6 bytes into a 4-deep FIFO, then drain
    obs_q.delete();
    dbi_csx = 1'b0;
    tick(4);
    for (int i = 0; i < 4; i++) wr_byte(DCX_PAR, 8'h10 + 8'(i));
    chk("full_no_ovf", ovf, 0);
    wr_byte(DCX_PAR, 8'h14);
    wr_byte(DCX_PAR, 8'h15);
    chk("ovf_set", ovf, 1);
    chk("ovf_vld", rx_vld, 1);
    dbi_csx = 1'b1;
    tick(4);
    rx_rdy = 1'b1;
    tick(8);
    rx_rdy = 1'b0;
    chk("ovf_drain_count", obs_q.size(), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      chk($sformatf("ovf_dat%0d", i), obs_q[i].dat, exp_ovf[i].dat);
      chk($sformatf("ovf_first%0d", i), obs_q[i].first, exp_ovf[i].first);
    end
    chk("ovf_sticky", ovf, 1);

    // Queue two bytes for the hardware-reset flush
    dbi_csx = 1'b0;
    tick(4);
    wr_byte(DCX_PAR, 8'h21);
    wr_byte(DCX_PAR, 8'h22);

    // Short RESX glitch: no effect
    h0 = hrst_cnt;
    dbi_resx = 1'b0;
    tick(400);
    dbi_resx = 1'b1;
    tick(10);
    chk("glitch_nohrst", hrst_cnt - h0, 0);
    chk("glitch_vld", rx_vld, 1);
    chk("glitch_ovf", ovf, 1);

    // Qualified RESX with WRX activity during the low period
    dbi_resx = 1'b0;
    for (int i = 0; i < 1300; i++) begin
      tick(1);
      if (i % 8 == 0) dbi_wrx = 1'b0;
      if (i % 8 == 4) dbi_wrx = 1'b1;
      if (i == 1000) chk("hrst_wr_ignored", rx_vld, 1);
      if (i == 1251) chk("hrst_early", hrst, 0);
      if (i == 1252) begin
        chk("hrst_pulse", hrst, 1);
        chk("hrst_flush", rx_vld, 0);
        chk("hrst_ovf_clr", ovf, 0);
      end
      if (i == 1253) chk("hrst_late", hrst, 0);
    end
    dbi_wrx = 1'b1;
    chk("hrst_hold_nopush", rx_vld, 0);
    dbi_resx = 1'b1;
    tick(6);
    chk("hrst_once", hrst_cnt - h0, 1);

    // CSX already low on return to idle: no capture without a new fall
    wr_byte(DCX_PAR, 8'h77);
    tick(2);
    chk("stale_csx_nopush", rx_vld, 0);
    dbi_csx = 1'b1;
    tick(4);

    // rst mid-transaction with two bytes queued
    dbi_csx = 1'b0;
    tick(4);
    wr_byte(DCX_CMD, 8'h31);
    wr_byte(DCX_PAR, 8'h32);
    chk("pre_rst_vld", rx_vld, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_vld", rx_vld, 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    wr_byte(DCX_PAR, 8'h33);
    tick(2);
    chk("post_rst_nopush", rx_vld, 0);
    dbi_csx = 1'b1;
    tick(4);
    dbi_csx = 1'b0;
    tick(4);
    wr_byte(DCX_PAR, 8'h34);
    chk("fresh_vld", rx_vld, 1);
    chk("fresh_dat", rx_dat, 8'h34);
    chk("fresh_first", rx_first, 1);
    dbi_csx = 1'b1;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
